// File: rtl/program_loader.sv
// program_loader: boot loader that receives a framed byte stream (2-byte word count,
// 4N big-endian payload bytes) and writes 32-bit words into instruction memory, holding
// the core in stall until a complete, well-formed program has been loaded.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and CHECK state.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic [31:0] WriteData,
  output logic [31:0] WriteAddress,
  output logic        WriteEnable,
  output logic        CoreHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsLoaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCheck, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StDone, StError
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;     // first three bytes of the word in flight
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] naddr_q, naddr_d;   // address the next completed word will use
  logic        we_q, we_d;
  logic [15:0] words_q, words_d;
  logic [31:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic accept;
  logic in_frame;

  assign in_frame     = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData)
`ifdef LOADER_CHECKSUM_EN
                        || (state_q == StCheck)
`endif
                        ;
  assign ByteReady    = in_frame;
  assign accept       = ByteValid && in_frame;
  assign WriteData    = wdata_q;
  assign WriteAddress = waddr_q;
  assign WriteEnable  = we_q;
  assign WordsLoaded  = words_q;
  assign Done         = done_q;
  assign Error        = error_q;
  // Done lags DONE entry by one cycle when no checksum is used, so hold follows Done.
  assign CoreHold     = ~done_q;

  // Next-state, word assembly, strobe generation and timeout supervision.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    naddr_d = naddr_q;
    we_d    = 1'b0;
    words_d = words_q;
    tmo_d   = tmo_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    if (in_frame) begin
      tmo_d = accept ? 32'd0 : tmo_q + 32'd1;
    end

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (Start) begin
          state_d = StLenHi;
          words_d = 16'd0;
          idx_d   = 2'd0;
          tmo_d   = 32'd0;
          naddr_d = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = ByteData;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = ByteData;
          if (({len_q[15:8], ByteData} == 16'd0) ||
              (32'({len_q[15:8], ByteData}) > MAX_WORDS)) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          idx_d  = idx_q + 2'd1;
          word_d = {word_q[15:0], ByteData};
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ ByteData;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, ByteData};
            waddr_d = naddr_q;
            naddr_d = naddr_q + 32'd4;
            words_d = words_q + 16'd1;
            if (words_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StDone;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          state_d = (ByteData == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Idle gap too long inside a frame aborts the load.
    if (in_frame && !accept && (tmo_q + 32'd1 >= TIMEOUT_CYCLES)) begin
      state_d = StError;
    end

`ifdef LOADER_CHECKSUM_EN
    done_d = (state_d == StDone) && ((state_q == StDone) || (state_q == StCheck));
`else
    done_d = (state_d == StDone) && (state_q == StDone);
`endif
    error_d = (state_d == StError);
  end

  // State register with synchronous active-low reset; reset drops any pending strobe.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      len_q   <= 16'd0;
      idx_q   <= 2'd0;
      word_q  <= 24'd0;
      wdata_q <= 32'd0;
      waddr_q <= BASE_ADDR;
      naddr_q <= BASE_ADDR;
      we_q    <= 1'b0;
      words_q <= 16'd0;
      tmo_q   <= 32'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      naddr_q <= naddr_d;
      we_q    <= we_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed steps in one initial block, expected
// memory writes queued on stimulus and compared when WriteEnable is observed.
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 4;
  localparam int unsigned TMO  = 20;

  logic        Clk = 1'b0;
  logic        Reset_n, Start, ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady, WriteEnable, CoreHold, Done, Error;
  logic [31:0] WriteData, WriteAddress;
  logic [15:0] WordsLoaded;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] next_addr;
  logic [7:0]  csum;

  always #5 Clk = ~Clk;

  program_loader #(
    .BASE_ADDR     (BASE),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .ByteValid   (ByteValid),
    .ByteData    (ByteData),
    .ByteReady   (ByteReady),
    .WriteData   (WriteData),
    .WriteAddress(WriteAddress),
    .WriteEnable (WriteEnable),
    .CoreHold    (CoreHold),
    .Done        (Done),
    .Error       (Error),
    .WordsLoaded (WordsLoaded)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the edge and score any write strobe.
  task automatic tick();
    wr_t e;
    @(posedge Clk);
    #1;
    if (WriteEnable !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_strobe", WriteEnable, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk32("wr_addr", WriteAddress, e.addr);
        chk32("wr_data", WriteData, e.data);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int n;
    if (rnd) begin
      for (int i = 0; i < 3 && $urandom_range(0, 1) == 1; i++) begin
        ByteValid = 1'b0;
        tick();
      end
    end
    ByteValid = 1'b1;
    ByteData  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = ByteReady;
      tick();
      n++;
    end
    ByteValid = 1'b0;
    if (!acc) chk1("byte_accept_timeout", 1'b0, 1'b1);
    else if (!rnd) chk32("throughput", 32'(n), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    wr_t e;
    e.addr = next_addr;
    e.data = w;
    exp_q.push_back(e);
    next_addr = next_addr + 32'd4;
    for (int i = 3; i >= 0; i--) begin
      csum = csum ^ w[i*8 +: 8];
      send_byte(w[i*8 +: 8], rnd);
    end
  endtask

  task automatic start_session();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    next_addr = BASE;
    csum = 8'h00;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
  endtask

  // Close a well-formed frame and confirm the successful-load levels.
  task automatic finish_ok(input int nwords);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 1'b0);
`else
    tick();
`endif
    chk1("ok_done", Done, 1'b1);
    chk1("ok_hold", CoreHold, 1'b0);
    chk1("ok_error", Error, 1'b0);
    chk32("ok_words", 32'(WordsLoaded), 32'(nwords));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    next_addr = BASE; csum = 8'h00;
    tick();
    tick();
    chk1("rst_ready", ByteReady, 1'b0);
    chk32("rst_wdata", WriteData, 32'h0);
    chk32("rst_waddr", WriteAddress, BASE);
    chk1("rst_we", WriteEnable, 1'b0);
    chk1("rst_hold", CoreHold, 1'b1);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_error", Error, 1'b0);
    chk32("rst_words", 32'(WordsLoaded), 32'd0);
    Reset_n = 1'b1;
    tick();
    chk1("idle_ready", ByteReady, 1'b0);

    // Basic two-word load with back-to-back bytes.
    start_session();
    chk1("start_ready", ByteReady, 1'b1);
    chk1("start_hold", CoreHold, 1'b1);
    send_len(16'd2);
    send_word(32'h2408_0005, 1'b0);
    send_word(32'h2409_0007, 1'b0);
`ifndef LOADER_CHECKSUM_EN
    chk1("we_cycle_done", Done, 1'b0);
    chk1("we_cycle_hold", CoreHold, 1'b1);
`endif
    finish_ok(2);
    chk1("done_ready", ByteReady, 1'b0);
    chk32("q_empty1", 32'(exp_q.size()), 32'd0);

    // Zero length.
    start_session();
    chk1("restart_done_clr", Done, 1'b0);
    send_len(16'd0);
    chk1("len0_error", Error, 1'b1);
    chk1("len0_hold", CoreHold, 1'b1);
    chk1("len0_done", Done, 1'b0);
    chk1("len0_ready", ByteReady, 1'b0);

    // Length one past the limit.
    start_session();
    chk1("restart_err_clr", Error, 1'b0);
    send_len(16'(MAXW + 1));
    chk1("lenmax1_error", Error, 1'b1);
    chk1("lenmax1_hold", CoreHold, 1'b1);
    chk32("lenmax1_words", 32'(WordsLoaded), 32'd0);

    // Same frame with random source gaps.
    start_session();
    send_len(16'd2);
    send_word(32'h2408_0005, 1'b1);
    send_word(32'h2409_0007, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 1'b1);
    chk1("rnd_done", Done, 1'b1);
`else
    finish_ok(2);
`endif

    // Largest legal frame.
    start_session();
    send_len(16'(MAXW));
    for (int i = 0; i < int'(MAXW); i++) send_word($urandom, 1'b0);
    finish_ok(int'(MAXW));

    // Timeout mid-word: error exactly after TMO idle cycles, count frozen.
    start_session();
    send_len(16'd2);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (TMO - 1) tick();
    chk1("tmo_not_yet", Error, 1'b0);
    tick();
    chk1("tmo_error", Error, 1'b1);
    chk1("tmo_hold", CoreHold, 1'b1);
    chk32("tmo_words", 32'(WordsLoaded), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then a correct reload.
    start_session();
    send_len(16'd2);
    send_word(32'h2408_0005, 1'b0);
    send_word(32'h2409_0007, 1'b0);
    send_byte(csum ^ 8'h01, 1'b0);
    chk1("csum_error", Error, 1'b1);
    chk1("csum_done", Done, 1'b0);
    chk1("csum_hold", CoreHold, 1'b1);
    start_session();
    send_len(16'd2);
    send_word(32'h2408_0005, 1'b0);
    send_word(32'h2409_0007, 1'b0);
    finish_ok(2);
`endif

    // Reset after six payload bytes.
    start_session();
    send_len(16'd2);
    send_word(32'hCAFE_0001, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk1("mrst_ready", ByteReady, 1'b0);
    chk1("mrst_hold", CoreHold, 1'b1);
    chk32("mrst_words", 32'(WordsLoaded), 32'd0);
    chk1("mrst_error", Error, 1'b0);
    ByteValid = 1'b1;
    ByteData  = 8'hFF;
    repeat (6) tick();
    ByteValid = 1'b0;
    chk1("mrst_idle_ready", ByteReady, 1'b0);
    chk32("mrst_words2", 32'(WordsLoaded), 32'd0);

    // Good load, then Start while in DONE re-asserts hold next cycle.
    start_session();
    send_len(16'd2);
    send_word(32'h2408_0005, 1'b0);
    send_word(32'h2409_0007, 1'b0);
    finish_ok(2);
    start_session();
    chk1("reload_hold", CoreHold, 1'b1);
    chk1("reload_done", Done, 1'b0);
    chk1("reload_ready", ByteReady, 1'b1);
    chk32("reload_words", 32'(WordsLoaded), 32'd0);

    chk32("q_empty_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
